// File: rtl/fb_write_ctrl.sv
// Frame-buffer port-B write controller: round-robin arbitration of two pixel
// requesters plus a full-screen clear sequencer. Define FB_WR_BOUNDS_CHECK_EN to drop off-screen writes.
module fb_write_ctrl #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              pixelClk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              busy,
    output logic              clear_done,
    input  logic              req0_valid,
    input  logic [9:0]        req0_x,
    input  logic [9:0]        req0_y,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [9:0]        req1_x,
    input  logic [9:0]        req1_y,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prio1;      // 1: req1 wins the next tie
    logic                r_web;
    logic [ADDR_W-1:0]   r_addrb;
    logic [DATA_W-1:0]   r_dinb;
    logic                r_clear_done;

    logic                w_web_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_din_nxt;
    logic                w_done_nxt;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic [9:0]          w_sel_x;
    logic [9:0]          w_sel_y;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_in_range;

    assign w_grant0   = req0_valid & (~req1_valid | ~r_prio1);
    assign w_grant1   = req1_valid & (~req0_valid |  r_prio1);
    assign req0_ready = (r_state == IDLE) & ~clear_req & w_grant0;
    assign req1_ready = (r_state == IDLE) & ~clear_req & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_sel_x    = req1_ready ? req1_x    : req0_x;
    assign w_sel_y    = req1_ready ? req1_y    : req0_y;
    assign w_sel_data = req1_ready ? req1_data : req0_data;
    assign w_req_addr = ADDR_W'(w_sel_x) + ADDR_W'(H_RES) * ADDR_W'(w_sel_y);

`ifdef FB_WR_BOUNDS_CHECK_EN
    logic [15:0] r_drop_cnt;

    assign w_in_range = (int'(w_sel_x) < H_RES) && (int'(w_sel_y) < V_RES);

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_in_range = 1'b1;
    assign drop_cnt   = '0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_web_nxt   = 1'b0;
        w_addr_nxt  = r_addrb;
        w_din_nxt   = r_dinb;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_web_nxt   = 1'b1;
                    w_addr_nxt  = '0;
                    w_din_nxt   = clear_color;
                end else if (w_accept && w_in_range) begin
                    w_web_nxt   = 1'b1;
                    w_addr_nxt  = w_req_addr;
                    w_din_nxt   = w_sel_data;
                end
            end
            CLEAR: begin
                // addrb doubles as the clear counter; dinb holds the latched colour
                if (r_addrb == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_web_nxt   = 1'b1;
                    w_addr_nxt  = r_addrb + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_prio1      <= 1'b0;
            r_web        <= 1'b0;
            r_addrb      <= '0;
            r_dinb       <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_web        <= w_web_nxt;
            r_addrb      <= w_addr_nxt;
            r_dinb       <= w_din_nxt;
            r_clear_done <= w_done_nxt;
            if (w_accept) begin
                r_prio1 <= req0_ready;
            end
        end
    end

    assign busy       = (r_state == CLEAR);
    assign clear_done = r_clear_done;
    assign web        = r_web;
    assign addrb      = r_addrb;
    assign dinb       = r_dinb;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl on a 640x16 buffer so a full clear stays short;
// requester writes are scored through an expected-write queue.
module tb_fb_write_ctrl;

    localparam int H = 640;
    localparam int V = 16;

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  data;
    } wr_t;

    logic        pixelClk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic [3:0]  clear_color;
    logic        busy, clear_done;
    logic        req0_valid, req1_valid;
    logic [9:0]  req0_x, req0_y, req1_x, req1_y;
    logic [3:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        web;
    logic [18:0] addrb;
    logic [3:0]  dinb;
    logic [15:0] drop_cnt;

    wr_t sb_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    fb_write_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(19), .DATA_W(4)) dut (
        .pixelClk(pixelClk), .reset(reset),
        .clear_req(clear_req), .clear_color(clear_color),
        .busy(busy), .clear_done(clear_done),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .web(web), .addrb(addrb), .dinb(dinb), .drop_cnt(drop_cnt)
    );

    always #5 pixelClk = ~pixelClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pixelClk);
        #1;
    endtask

    task automatic push(input int x, input int y, input logic [3:0] d);
        wr_t w;
        w.addr = 19'(x + H * y);
        w.data = d;
        sb_q.push_back(w);
    endtask

    // Any write outside a clear must match the oldest expected requester write.
    always @(negedge pixelClk) begin
        if (web === 1'b1 && busy === 1'b0) begin
            if (sb_q.size() == 0) begin
                check("stale_write", 32'(web), 32'd0);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                check("wr_addr", 32'(addrb), 32'(w.addr));
                check("wr_data", 32'(dinb), 32'(w.data));
            end
        end
    end

    initial begin
        int  c;
        int  errs;
        bit  seen;

        reset = 1'b1; clear_req = 1'b0; clear_color = '0;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_data = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_data = '0;
        tick(); tick();
        @(negedge pixelClk);
        check("rst_web", 32'(web), 32'd0);
        check("rst_addrb", 32'(addrb), 32'd0);
        check("rst_dinb", 32'(dinb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        tick(); reset = 1'b0;
        @(negedge pixelClk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);

        // Single req0 write: address 5 + 640*2 = 1285
        tick(); req0_valid = 1'b1; req0_x = 10'd5; req0_y = 10'd2; req0_data = 4'hA;
        @(negedge pixelClk);
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_ready1", 32'(req1_ready), 32'd0);
        push(5, 2, 4'hA);
        tick(); req0_valid = 1'b0;
        @(negedge pixelClk);
        check("single_web", 32'(web), 32'd1);
        check("single_addr_1285", 32'(addrb), 32'd1285);
        check("single_ready0_off", 32'(req0_ready), 32'd0);
        tick();
        @(negedge pixelClk);
        check("idle_web_off", 32'(web), 32'd0);

        // req1 alone at the last address; leaves the pointer favouring req0
        tick(); req1_valid = 1'b1; req1_x = 10'd639; req1_y = 10'd15; req1_data = 4'hF;
        @(negedge pixelClk);
        check("r1_ready1", 32'(req1_ready), 32'd1);
        check("r1_ready0", 32'(req0_ready), 32'd0);
        push(639, 15, 4'hF);

        // Both valid for 4 cycles: req0, req1, req0, req1
        tick();
        req0_valid = 1'b1; req0_x = 10'd10; req0_y = 10'd3; req0_data = 4'h1;
        req1_valid = 1'b1; req1_x = 10'd20; req1_y = 10'd4; req1_data = 4'h2;
        for (int k = 0; k < 4; k++) begin
            @(negedge pixelClk);
            check("rr_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            check("rr_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            if (k % 2 == 0) push(10, 3, 4'h1);
            else            push(20, 4, 4'h2);
            if (k > 0) check("rr_web_b2b", 32'(web), 32'd1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge pixelClk);
        check("rr_web_last", 32'(web), 32'd1);
        tick();
        @(negedge pixelClk);
        check("rr_web_off", 32'(web), 32'd0);

        // Full clear with colour 3 while req1 waits; re-pulsed clear_req mid-clear is ignored
        tick();
        clear_req = 1'b1; clear_color = 4'h3;
        req1_valid = 1'b1; req1_x = 10'd100; req1_y = 10'd7; req1_data = 4'h6;
        @(negedge pixelClk);
        check("clr_ready1_blocked", 32'(req1_ready), 32'd0);
        tick(); clear_req = 1'b0; clear_color = 4'h0;
        c = 0; errs = 0; seen = 1'b0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge pixelClk);
            if (clear_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1 || web !== 1'b1 || addrb !== 19'(c) || dinb !== 4'h3 ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0) errs++;
                c++;
                tick();
                clear_req   = (c == 100);
                clear_color = (c == 100) ? 4'h5 : 4'h0;
            end
        end
        check("clr_done_seen", 32'(seen), 32'd1);
        check("clr_length", 32'(c), 32'(H * V));
        check("clr_seq_errors", 32'(errs), 32'd0);
        check("clr_busy_off", 32'(busy), 32'd0);
        check("clr_ready1_at_done", 32'(req1_ready), 32'd1);
        push(100, 7, 4'h6);
        tick(); req1_valid = 1'b0;
        @(negedge pixelClk);
        check("clr_done_pulse", 32'(clear_done), 32'd0);
        check("clr_busy_stays_off", 32'(busy), 32'd0);

        // req0 write so the pointer favours req1 before the reset test
        tick(); req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd0; req0_data = 4'hC;
        @(negedge pixelClk);
        check("pre_rst_ready0", 32'(req0_ready), 32'd1);
        push(1, 0, 4'hC);
        tick(); req0_valid = 1'b0;

        // Reset while the clear is writing address 1000
        clear_req = 1'b1; clear_color = 4'h7;
        tick(); clear_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge pixelClk);
            if (addrb === 19'd1000) seen = 1'b1;
        end
        check("rst_mid_reached_1000", 32'(seen), 32'd1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge pixelClk);
        check("mid_rst_web", 32'(web), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addrb", 32'(addrb), 32'd0);
        check("mid_rst_done", 32'(clear_done), 32'd0);
        tick();
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_data = 4'h4;
        req1_valid = 1'b1; req1_x = 10'd2; req1_y = 10'd2; req1_data = 4'h5;
        @(negedge pixelClk);
        check("ptr_rst_ready0", 32'(req0_ready), 32'd1);
        check("ptr_rst_ready1", 32'(req1_ready), 32'd0);
        push(1, 1, 4'h4);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge pixelClk);
        check("mid_rst_no_done", 32'(clear_done), 32'd0);

        // Out-of-range column
        tick(); req0_valid = 1'b1; req0_x = 10'd640; req0_y = 10'd0; req0_data = 4'h9;
        @(negedge pixelClk);
        check("oob_ready0", 32'(req0_ready), 32'd1);
`ifndef FB_WR_BOUNDS_CHECK_EN
        push(640, 0, 4'h9);
`endif
        tick(); req0_valid = 1'b0;
        @(negedge pixelClk);
`ifdef FB_WR_BOUNDS_CHECK_EN
        check("oob_no_web", 32'(web), 32'd0);
        check("oob_drop1", 32'(drop_cnt), 32'd1);
`else
        check("oob_web", 32'(web), 32'd1);
        check("oob_drop_tied", 32'(drop_cnt), 32'd0);
`endif

        // Last in-range pixel, then an out-of-range row
        tick(); req0_valid = 1'b1; req0_x = 10'd639; req0_y = 10'd15; req0_data = 4'hE;
        @(negedge pixelClk);
        push(639, 15, 4'hE);
        tick(); req0_x = 10'd0; req0_y = 10'd16; req0_data = 4'h8;
        @(negedge pixelClk);
        check("edge_web", 32'(web), 32'd1);
        check("edge_addr", 32'(addrb), 32'(H * V - 1));
        check("oob_row_ready0", 32'(req0_ready), 32'd1);
`ifndef FB_WR_BOUNDS_CHECK_EN
        push(0, 16, 4'h8);
`endif
        tick(); req0_valid = 1'b0;
        @(negedge pixelClk);
`ifdef FB_WR_BOUNDS_CHECK_EN
        check("oob_row_no_web", 32'(web), 32'd0);
        check("oob_drop2", 32'(drop_cnt), 32'd2);
`else
        check("oob_row_web", 32'(web), 32'd1);
        check("oob_row_drop_tied", 32'(drop_cnt), 32'd0);
`endif

        tick(); tick();
        @(negedge pixelClk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
